display_scan4: RTL and testbench
================================

DISPLAY_SCAN4 -- requirements
Module: display_scan4

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit stays lit. Legal range is 2..65535.
REQ-002 Parameter BLINK_DIV, default 2: scan frames per blink half-period. Legal range is 1..255.
REQ-003 Parameter LZB, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 clear  in  1  reset, asynchronous and active-high.
REQ-006 enable  in  1  1 = scan runs; 0 = freeze scan and turn the display off.
REQ-007 digit0..digit3  in  4 each  BCD digits from the counter cascade; digit0 is the least significant.
REQ-008 count_end  in  1  terminal flag from the counter cascade; requests blinking.
REQ-009 an  out  4  one-hot digit select, active-high; bit i lights digit i.
REQ-010 seg  out  7  segments {g,f,e,d,c,b,a}, active-high.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 while enable=1. "tick" = prescaler at SCAN_DIV-1; on tick the prescaler wraps to 0.
REQ-012 Select register sel (2 bits) SHALL advance 0->1->2->3->0 on each tick. One frame = 4*SCAN_DIV cycles.
REQ-013 The tick with sel=3 is a frame wrap. On it, a 16-bit snapshot SHALL load digit0..3 in the same cycle sel returns to 0. Input changes mid-frame SHALL NOT show until the next frame.
REQ-014 an and seg SHALL be registered.
- While enable=1, each edge sets an=onehot(next sel) and seg=decode(snapshot digit selected by next sel).
- New data therefore appears on the edge where sel changes.
REQ-015 Decode table: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Any value 10..15 SHALL decode to 0x40 (dash).
REQ-016 With LZB=1, leading zeros SHALL be blanked (seg=0x00 while an stays driven):
- digit3 is blanked if it is 0;
- digit2 is blanked if digit3 and digit2 are both 0;
- digit1 is blanked if digit3..digit1 are all 0;
- digit0 is never blanked.
REQ-017 enable=0 SHALL hold the prescaler, sel and snapshot, and register an=0000 and seg=0x00 on the next edge. When enable returns to 1, scanning SHALL resume from the held sel and prescaler values.
REQ-018 The snapshot SHALL load only on a frame wrap; enable=0 therefore also blocks snapshot updates.

Reset
REQ-019 While clear=1, all outputs and state SHALL be forced immediately, without waiting for a clock edge:
- prescaler=0, sel=0, snapshot=0;
- blink frame counter=0, blink phase=0;
- an=0000, seg=0x00.
REQ-020 On the first edge after clear falls with enable=1, outputs SHALL be an=0001 and seg=0x3F (snapshot digit0=0).
REQ-021 clear asserted mid-frame SHALL abandon the frame. The next frame SHALL start at sel=0 with a full SCAN_DIV dwell.

Configuration
REQ-022 Macro DISPLAY_SCAN4_BLINK_EN selects blinking.
REQ-023 With the macro defined, blinking behaves as follows:
- While count_end=1, a frame counter SHALL count frame wraps.
- On every BLINK_DIV-th wrap, the blink phase SHALL toggle.
- While the phase is 1, an SHALL be 0000; seg is don't-care.
- count_end=0 SHALL clear the counter and phase synchronously, so the display is on immediately.
REQ-024 With the macro undefined:
- count_end SHALL be ignored, but the port SHALL remain;
- no blink logic SHALL be synthesized;
- the display SHALL never blank for blinking.

Verification (SCAN_DIV=4, BLINK_DIV=2, LZB=1)
REQ-025 Digits 4,3,2,1 (d0..d3), enable=1 -> after the first frame wrap, the bench SHALL see:
- an=0001, seg=0x66 for 4 cycles;
- then 0010/0x4F, then 0100/0x5B, then 1000/0x06;
- repeating with period 16.
REQ-026 Digits d3=0, d2=0, d1=5, d0=0 -> the bench SHALL see:
- digit3 and digit2 at seg=0x00;
- digit1 at seg=0x6D;
- digit0 at seg=0x3F.
REQ-027 d0=4'hB -> seg=0x40 while an=0001. Digits changed while sel=1 -> outputs SHALL be unchanged until the next frame.
REQ-028 clear pulsed while sel=2 -> an=0000 and seg=0x00 without a clock edge. After release, an=0001 and seg=0x3F on the first edge.
REQ-029 enable=0 for 10 cycles at sel=1 -> an=0000 throughout. After enable returns, digit1 SHALL finish its remaining dwell.
REQ-030 With DISPLAY_SCAN4_BLINK_EN, count_end=1 -> the bench SHALL see:
- 2 frames lit;
- 2 frames with an=0000;
- repeating thereafter.
Dropping count_end during a dark frame -> an SHALL light on the next edge.

Source files
------------

// File: rtl/display_scan4.sv
// Four-digit multiplexed 7-segment scanner with per-frame digit snapshot and leading-zero blanking.
// Optional blinking on count_end is built only when DISPLAY_SCAN4_BLINK_EN is defined.
module display_scan4 #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 2,
  parameter int LZB       = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       count_end,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] presc, presc_next;
  logic [1:0]  sel, sel_next;
  logic [15:0] snap, snap_next;
  logic        tick, wrap, dark, blank;
  logic [3:0]  cur_digit, an_next;
  logic [6:0]  seg_next;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Everything below is computed from next-state values so the registered
  // outputs change on the same edge as sel and the snapshot.
  always_comb begin
    tick       = enable && (presc == PRESC_MAX);
    wrap       = tick && (sel == 2'd3);
    presc_next = presc;
    if (enable) presc_next = tick ? 16'd0 : presc + 16'd1;
    sel_next   = tick ? sel + 2'd1 : sel;
    snap_next  = wrap ? {digit3, digit2, digit1, digit0} : snap;
  end

  always_comb begin
    cur_digit = snap_next[3:0];
    blank     = 1'b0;
    case (sel_next)
      2'd0: begin
        cur_digit = snap_next[3:0];
        blank     = 1'b0;
      end
      2'd1: begin
        cur_digit = snap_next[7:4];
        blank     = (LZB != 0) && (snap_next[15:4] == 12'd0);
      end
      2'd2: begin
        cur_digit = snap_next[11:8];
        blank     = (LZB != 0) && (snap_next[15:8] == 8'd0);
      end
      default: begin
        cur_digit = snap_next[15:12];
        blank     = (LZB != 0) && (snap_next[15:12] == 4'd0);
      end
    endcase
  end

`ifdef DISPLAY_SCAN4_BLINK_EN
  localparam logic [7:0] BLINK_MAX = 8'(BLINK_DIV - 1);

  logic [7:0] bcnt, bcnt_next;
  logic       phase, phase_next;

  // Dropping count_end clears the phase combinationally into an_next, so the
  // display relights on the very next edge.
  always_comb begin
    bcnt_next  = bcnt;
    phase_next = phase;
    if (!count_end) begin
      bcnt_next  = 8'd0;
      phase_next = 1'b0;
    end else if (wrap) begin
      if (bcnt == BLINK_MAX) begin
        bcnt_next  = 8'd0;
        phase_next = ~phase;
      end else begin
        bcnt_next = bcnt + 8'd1;
      end
    end
    dark = phase_next;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      bcnt  <= 8'd0;
      phase <= 1'b0;
    end else begin
      bcnt  <= bcnt_next;
      phase <= phase_next;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = count_end ^ (BLINK_DIV == 0);
  assign dark = 1'b0;
`endif

  always_comb begin
    an_next  = 4'b0000;
    seg_next = 7'h00;
    if (enable) begin
      if (!dark) an_next = 4'b0001 << sel_next;
      seg_next = blank ? 7'h00 : decode(cur_digit);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      presc <= 16'd0;
      sel   <= 2'd0;
      snap  <= 16'd0;
      an    <= 4'b0000;
      seg   <= 7'h00;
    end else begin
      presc <= presc_next;
      sel   <= sel_next;
      snap  <= snap_next;
      an    <= an_next;
      seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_display_scan4.sv
// Bench for display_scan4 (SCAN_DIV=4, BLINK_DIV=2, LZB=1): digit-pattern table plus
// mid-frame update, clear, enable-freeze and count_end sequences.
module tb_display_scan4;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] digit0 = 4'd0;
  logic [3:0] digit1 = 4'd0;
  logic [3:0] digit2 = 4'd0;
  logic [3:0] digit3 = 4'd0;
  logic       count_end = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  // Entry: {compare_seg, an, seg}
  logic [11:0] exp_q[$];

  typedef struct packed {
    logic [15:0] digits;  // {d3,d2,d1,d0}
    logic [27:0] segs;    // {s3,s2,s1,s0}
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  display_scan4 #(
    .SCAN_DIV (4),
    .BLINK_DIV(2),
    .LZB      (1)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .enable   (enable),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .count_end(count_end),
    .an       (an),
    .seg      (seg)
  );

  task automatic check_out(input string name, input logic [3:0] ea, input logic [6:0] es,
                           input logic care_seg);
    checks++;
    if (an !== ea || (care_seg && seg !== es)) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h%s", name, an, seg, ea, es,
               care_seg ? "" : " (seg ignored)");
    end
  endtask

  task automatic push_run(input logic [3:0] a, input logic [6:0] s, input int n,
                          input logic care);
    repeat (n) exp_q.push_back({care, a, s});
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic lit);
    for (int d = 0; d < 4; d++)
      push_run(lit ? 4'(1 << d) : 4'b0000, segs[d*7 +: 7], 4, lit);
  endtask

  // Frame right after clear: snapshot is zero, first dwell is one cycle short on the outputs.
  task automatic push_first_frame();
    push_run(4'b0001, 7'h3F, 3, 1'b1);
    push_run(4'b0010, 7'h00, 4, 1'b1);
    push_run(4'b0100, 7'h00, 4, 1'b1);
    push_run(4'b1000, 7'h00, 4, 1'b1);
  endtask

  task automatic run_edges(input string name, input int n);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty at edge %0d, got an=%b seg=%h", name, i, an, seg);
      end else begin
        e = exp_q.pop_front();
        check_out($sformatf("%s_e%0d", name, i), e[10:7], e[6:0], e[11]);
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] dig);
    @(negedge clk);
    clear = 1'b1;
    #1 check_out("reset_async", 4'b0000, 7'h00, 1'b1);
    {digit3, digit2, digit1, digit0} = dig;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got time %0t, expected < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{digits: 16'h1234, segs: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1]  = '{digits: 16'h0050, segs: {7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[2]  = '{digits: 16'h987B, segs: {7'h6F, 7'h7F, 7'h07, 7'h40}};
    vecs[3]  = '{digits: 16'h0000, segs: {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[4]  = '{digits: 16'h0006, segs: {7'h00, 7'h00, 7'h00, 7'h7D}};
    vecs[5]  = '{digits: 16'h0100, segs: {7'h00, 7'h06, 7'h3F, 7'h3F}};
    vecs[6]  = '{digits: 16'hF000, segs: {7'h40, 7'h3F, 7'h3F, 7'h3F}};
    vecs[7]  = '{digits: 16'h0A0C, segs: {7'h00, 7'h40, 7'h3F, 7'h40}};
    vecs[8]  = '{digits: 16'h6789, segs: {7'h7D, 7'h07, 7'h7F, 7'h6F}};
    vecs[9]  = '{digits: 16'h5000, segs: {7'h6D, 7'h3F, 7'h3F, 7'h3F}};
    vecs[10] = '{digits: 16'h00D1, segs: {7'h00, 7'h00, 7'h40, 7'h06}};

    for (int i = 0; i < 11; i++) begin
      do_reset(vecs[i].digits);
      push_first_frame();
      push_frame(vecs[i].segs, 1'b1);
      run_edges($sformatf("vec%0d", i), 31);
    end

    // Digits changed while sel=1 stay hidden until the next frame wrap.
    do_reset(16'h4321);
    push_first_frame();
    push_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 1'b1);
    push_frame({7'h7F, 7'h07, 7'h7D, 7'h6D}, 1'b1);
    run_edges("midframe_a", 21);
    {digit3, digit2, digit1, digit0} = 16'h8765;
    run_edges("midframe_b", 26);

    // Clear while sel=2 blanks without a clock edge; restart with a fresh frame.
    do_reset(16'h1234);
    push_first_frame();
    push_run(4'b0001, 7'h66, 4, 1'b1);
    push_run(4'b0010, 7'h4F, 4, 1'b1);
    push_run(4'b0100, 7'h5B, 2, 1'b1);
    run_edges("preclear", 25);
    clear = 1'b1;
    #1 check_out("clear_midframe_async", 4'b0000, 7'h00, 1'b1);
    @(posedge clk);
    #1 check_out("clear_held", 4'b0000, 7'h00, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    push_first_frame();
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1);
    run_edges("postclear", 31);

    // enable=0 for 10 cycles during digit1's dwell; digit1 then finishes its remaining 2 cycles.
    do_reset(16'h1234);
    push_first_frame();
    push_run(4'b0001, 7'h66, 4, 1'b1);
    push_run(4'b0010, 7'h4F, 2, 1'b1);
    run_edges("preenable", 21);
    enable = 1'b0;
    push_run(4'b0000, 7'h00, 10, 1'b1);
    run_edges("disabled", 10);
    enable = 1'b1;
    push_run(4'b0010, 7'h4F, 2, 1'b1);
    push_run(4'b0100, 7'h5B, 4, 1'b1);
    push_run(4'b1000, 7'h06, 4, 1'b1);
    push_run(4'b0001, 7'h66, 4, 1'b1);
    run_edges("resumed", 14);

    // count_end held high, then dropped during a dark frame (edge 100, sel=1).
    count_end = 1'b1;
    do_reset(16'h1234);
    push_first_frame();
`ifdef DISPLAY_SCAN4_BLINK_EN
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1);
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0);
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0);
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1);
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1);
    push_run(4'b0000, 7'h00, 5, 1'b0);
`else
    for (int f = 0; f < 5; f++) push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1);
    push_run(4'b0001, 7'h66, 4, 1'b1);
    push_run(4'b0010, 7'h4F, 1, 1'b1);
`endif
    run_edges("blink", 100);
    count_end = 1'b0;
    push_run(4'b0010, 7'h4F, 3, 1'b1);
    push_run(4'b0100, 7'h5B, 4, 1'b1);
    run_edges("blink_drop", 7);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
